// File: rtl/sy_l2_cache_array_if.sv
// Request/response bundle between the L2 controller pipeline (master) and
// the L2 tag/state/data array (slave).
interface sy_l2_cache_array_if #(
  parameter int WAY_NUM  = 4,
  parameter int SET_NUM  = 256,
  parameter int TAG_WTH  = 20,
  parameter int DATA_WTH = 64,
  parameter int BEAT_NUM = 8
) ();
  localparam int IDX_W  = $clog2(SET_NUM);
  localparam int DIDX_W = $clog2(SET_NUM*BEAT_NUM);

  logic                               flush_req_i;
  logic                               flush_busy_o;
  logic                               flush_done_o;

  logic                               tag_req_i;
  logic                               tag_ready_o;
  logic                               tag_we_i;
  logic [WAY_NUM-1:0]                 tag_way_en_i;
  logic [IDX_W-1:0]                   tag_idx_i;
  logic [TAG_WTH-1:0]                 tag_i;
  logic                               tag_valid_i;
  logic                               tag_dirty_i;
  logic                               tag_rsp_valid_o;
  logic [WAY_NUM-1:0][TAG_WTH-1:0]    tag_rsp_tag_o;
  logic [WAY_NUM-1:0]                 tag_rsp_valid_bits_o;
  logic [WAY_NUM-1:0]                 tag_rsp_dirty_o;
  logic [WAY_NUM-1:0]                 tag_rsp_hit_o;

  logic                               data_req_i;
  logic                               data_we_i;
  logic [WAY_NUM-1:0]                 data_way_en_i;
  logic [DIDX_W-1:0]                  data_idx_i;
  logic [DATA_WTH-1:0]                data_wdata_i;
  logic [DATA_WTH/8-1:0]              data_wstrb_i;
  logic                               data_rsp_valid_o;
  logic [WAY_NUM-1:0][DATA_WTH-1:0]   data_rdata_o;

  modport slave (
    input  flush_req_i,
    output flush_busy_o, flush_done_o,
    input  tag_req_i, tag_we_i, tag_way_en_i, tag_idx_i, tag_i, tag_valid_i, tag_dirty_i,
    output tag_ready_o, tag_rsp_valid_o, tag_rsp_tag_o, tag_rsp_valid_bits_o,
           tag_rsp_dirty_o, tag_rsp_hit_o,
    input  data_req_i, data_we_i, data_way_en_i, data_idx_i, data_wdata_i, data_wstrb_i,
    output data_rsp_valid_o, data_rdata_o
  );

  modport master (
    output flush_req_i,
    input  flush_busy_o, flush_done_o,
    output tag_req_i, tag_we_i, tag_way_en_i, tag_idx_i, tag_i, tag_valid_i, tag_dirty_i,
    input  tag_ready_o, tag_rsp_valid_o, tag_rsp_tag_o, tag_rsp_valid_bits_o,
           tag_rsp_dirty_o, tag_rsp_hit_o,
    output data_req_i, data_we_i, data_way_en_i, data_idx_i, data_wdata_i, data_wstrb_i,
    input  data_rsp_valid_o, data_rdata_o
  );
endinterface

// File: rtl/sy_l2_cache_array.sv
// L2 tag/state/data array with a one-set-per-cycle valid/dirty sweep engine.
// Optional tag-entry parity: define SY_L2_ARRAY_PARITY_EN.
module sy_l2_cache_array #(
  parameter int WAY_NUM  = 4,
  parameter int SET_NUM  = 256,
  parameter int TAG_WTH  = 20,
  parameter int DATA_WTH = 64,
  parameter int BEAT_NUM = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sy_l2_cache_array_if.slave    bus
`ifdef SY_L2_ARRAY_PARITY_EN
  ,
  output logic [WAY_NUM-1:0]    tag_parity_err_o
`endif
);
  localparam int IDX_W  = $clog2(SET_NUM);
  localparam int DIDX_W = $clog2(SET_NUM*BEAT_NUM);
  localparam int STRB_W = DATA_WTH/8;
  localparam int LINES  = SET_NUM*BEAT_NUM;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             busy_q, done_q;

  // Reset lands directly in SWEEP so the array is scrubbed before first use.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.flush_req_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IDX_W'(SET_NUM-1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  logic tag_ready, tag_rd, tag_wr, sweep;
  assign tag_ready        = (state_q == IDLE) && !bus.flush_req_i;
  assign tag_rd           = bus.tag_req_i && tag_ready && !bus.tag_we_i;
  assign tag_wr           = bus.tag_req_i && tag_ready &&  bus.tag_we_i;
  assign sweep            = (state_q == SWEEP);
  assign bus.tag_ready_o  = tag_ready;
  assign bus.flush_busy_o = busy_q;
  assign bus.flush_done_o = done_q;

  // Tag storage is never cleared; only valid/dirty (and parity) are swept.
  logic [TAG_WTH-1:0]                tag_mem [WAY_NUM][SET_NUM];
  logic [WAY_NUM-1:0][SET_NUM-1:0]   vld_q, dty_q;
`ifdef SY_L2_ARRAY_PARITY_EN
  logic [WAY_NUM-1:0][SET_NUM-1:0]   par_q;
`endif

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < WAY_NUM; w++)
      if (tag_wr && bus.tag_way_en_i[w])
        tag_mem[w][bus.tag_idx_i] <= bus.tag_i;
  end

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < WAY_NUM; w++) begin
      if (sweep) begin
        vld_q[w][cnt_q] <= 1'b0;
        dty_q[w][cnt_q] <= 1'b0;
`ifdef SY_L2_ARRAY_PARITY_EN
        par_q[w][cnt_q] <= 1'b0;
`endif
      end else if (tag_wr && bus.tag_way_en_i[w]) begin
        vld_q[w][bus.tag_idx_i] <= bus.tag_valid_i;
        dty_q[w][bus.tag_idx_i] <= bus.tag_dirty_i;
`ifdef SY_L2_ARRAY_PARITY_EN
        par_q[w][bus.tag_idx_i] <= ^{bus.tag_i, bus.tag_valid_i, bus.tag_dirty_i};
`endif
      end
    end
  end

  logic [WAY_NUM-1:0][TAG_WTH-1:0] rd_tag;
  logic [WAY_NUM-1:0]              rd_vld, rd_dty, rd_perr, rd_hit;

  always_comb begin
    rd_tag  = '0;
    rd_vld  = '0;
    rd_dty  = '0;
    rd_perr = '0;
    rd_hit  = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      rd_tag[w] = tag_mem[w][bus.tag_idx_i];
      rd_vld[w] = vld_q[w][bus.tag_idx_i];
      rd_dty[w] = dty_q[w][bus.tag_idx_i];
`ifdef SY_L2_ARRAY_PARITY_EN
      rd_perr[w] = (^{rd_tag[w], rd_vld[w], rd_dty[w]}) != par_q[w][bus.tag_idx_i];
`endif
      rd_hit[w] = rd_vld[w] && (rd_tag[w] == bus.tag_i) && !rd_perr[w];
    end
  end

  logic                            tag_rsp_vld_q;
  logic [WAY_NUM-1:0][TAG_WTH-1:0] tag_rsp_tag_q;
  logic [WAY_NUM-1:0]              tag_rsp_vbits_q, tag_rsp_dty_q, tag_rsp_hit_q, tag_rsp_perr_q;

  // Tag field holds between reads; the per-way flags only live for one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_rsp_vld_q   <= 1'b0;
      tag_rsp_tag_q   <= '0;
      tag_rsp_vbits_q <= '0;
      tag_rsp_dty_q   <= '0;
      tag_rsp_hit_q   <= '0;
      tag_rsp_perr_q  <= '0;
    end else begin
      tag_rsp_vld_q <= tag_rd;
      if (tag_rd) begin
        for (int w = 0; w < WAY_NUM; w++)
          tag_rsp_tag_q[w] <= bus.tag_way_en_i[w] ? rd_tag[w] : '0;
        tag_rsp_vbits_q <= bus.tag_way_en_i & rd_vld;
        tag_rsp_dty_q   <= bus.tag_way_en_i & rd_dty;
        tag_rsp_hit_q   <= bus.tag_way_en_i & rd_hit;
        tag_rsp_perr_q  <= bus.tag_way_en_i & rd_perr;
      end else begin
        tag_rsp_vbits_q <= '0;
        tag_rsp_dty_q   <= '0;
        tag_rsp_hit_q   <= '0;
        tag_rsp_perr_q  <= '0;
      end
    end
  end

  assign bus.tag_rsp_valid_o      = tag_rsp_vld_q;
  assign bus.tag_rsp_tag_o        = tag_rsp_tag_q;
  assign bus.tag_rsp_valid_bits_o = tag_rsp_vbits_q;
  assign bus.tag_rsp_dirty_o      = tag_rsp_dty_q;
  assign bus.tag_rsp_hit_o        = tag_rsp_hit_q;
`ifdef SY_L2_ARRAY_PARITY_EN
  assign tag_parity_err_o         = tag_rsp_perr_q;
`else
  logic unused_perr;
  assign unused_perr = ^tag_rsp_perr_q;
`endif

  // Data path: always ready and independent of the sweep.
  logic [DATA_WTH-1:0] data_mem [WAY_NUM][LINES];
  logic                data_rd, data_wr;
  assign data_rd = bus.data_req_i && !bus.data_we_i;
  assign data_wr = bus.data_req_i &&  bus.data_we_i;

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < WAY_NUM; w++)
      for (int b = 0; b < STRB_W; b++)
        if (data_wr && bus.data_way_en_i[w] && bus.data_wstrb_i[b])
          data_mem[w][bus.data_idx_i][b*8 +: 8] <= bus.data_wdata_i[b*8 +: 8];
  end

  logic                             data_rsp_vld_q;
  logic [WAY_NUM-1:0][DATA_WTH-1:0] data_rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_rsp_vld_q <= 1'b0;
      data_rdata_q   <= '0;
    end else begin
      data_rsp_vld_q <= data_rd;
      if (data_rd)
        for (int w = 0; w < WAY_NUM; w++)
          data_rdata_q[w] <= bus.data_way_en_i[w] ? data_mem[w][bus.data_idx_i] : '0;
    end
  end

  assign bus.data_rsp_valid_o = data_rsp_vld_q;
  assign bus.data_rdata_o     = data_rdata_q;

endmodule

// File: tb/tb_sy_l2_cache_array.sv
// Self-checking bench for sy_l2_cache_array: vector table, sweep corner
// sequences and randomized traffic against an array-based reference model.
module tb_sy_l2_cache_array;
  localparam int WAY_NUM = 4, SET_NUM = 256, TAG_WTH = 20, DATA_WTH = 64, BEAT_NUM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sy_l2_cache_array_if #(.WAY_NUM(WAY_NUM), .SET_NUM(SET_NUM), .TAG_WTH(TAG_WTH),
                         .DATA_WTH(DATA_WTH), .BEAT_NUM(BEAT_NUM)) bus ();
`ifdef SY_L2_ARRAY_PARITY_EN
  logic [WAY_NUM-1:0] perr;
`endif

  sy_l2_cache_array #(.WAY_NUM(WAY_NUM), .SET_NUM(SET_NUM), .TAG_WTH(TAG_WTH),
                      .DATA_WTH(DATA_WTH), .BEAT_NUM(BEAT_NUM)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
`ifdef SY_L2_ARRAY_PARITY_EN
    , .tag_parity_err_o(perr)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    bus.flush_req_i   = 1'b0;
    bus.tag_req_i     = 1'b0;
    bus.tag_we_i      = 1'b0;
    bus.tag_way_en_i  = '0;
    bus.tag_idx_i     = '0;
    bus.tag_i         = '0;
    bus.tag_valid_i   = 1'b0;
    bus.tag_dirty_i   = 1'b0;
    bus.data_req_i    = 1'b0;
    bus.data_we_i     = 1'b0;
    bus.data_way_en_i = '0;
    bus.data_idx_i    = '0;
    bus.data_wdata_i  = '0;
    bus.data_wstrb_i  = '0;
  endtask

  task automatic tag_op(input logic we, input logic [3:0] en, input logic [7:0] idx,
                        input logic [19:0] tag, input logic v, input logic d);
    bus.tag_req_i = 1'b1; bus.tag_we_i = we; bus.tag_way_en_i = en;
    bus.tag_idx_i = idx;  bus.tag_i = tag;   bus.tag_valid_i = v; bus.tag_dirty_i = d;
  endtask

  task automatic data_op(input logic we, input logic [3:0] en, input logic [10:0] idx,
                         input logic [63:0] wd, input logic [7:0] strb);
    bus.data_req_i = 1'b1; bus.data_we_i = we; bus.data_way_en_i = en;
    bus.data_idx_i = idx;  bus.data_wdata_i = wd; bus.data_wstrb_i = strb;
  endtask

  // Called on a negedge where busy is already visible; counts busy samples.
  task automatic wait_sweep(input string name, input int exp_busy);
    int n = 0;
    while (bus.flush_busy_o && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy cycles"}, 256'(n), 256'(exp_busy));
    chk({name, " done pulse"}, 256'(bus.flush_done_o), 256'(1));
    chk({name, " ready in done"}, 256'(bus.tag_ready_o), 256'(0));
    @(negedge clk);
    chk({name, " done width"}, 256'(bus.flush_done_o), 256'(0));
    chk({name, " ready after"}, 256'(bus.tag_ready_o), 256'(1));
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  en;
    logic [7:0]  idx;
    logic [19:0] tag;
    logic        v, d;
    logic [3:0]  e_hit, e_vld, e_dty;
    int          tw;
    logic [19:0] e_tag;
  } vec_t;

  vec_t vec[10];

  // Reference model state
  logic [19:0] mt [4][8];
  bit          mv [4][8];
  bit          md [4][8];
  logic [63:0] mdat [4][16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][63:0] edat;
    logic [3:0][19:0] etag;
    logic [3:0]       ev, ed, eh;
    int               bad;
    logic [19:0]      pool [4];

    vec[0] = '{1'b1, 4'b0100, 8'h15, 20'hABCDE, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 0, 20'h0};
    vec[1] = '{1'b0, 4'b1111, 8'h15, 20'hABCDE, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 2, 20'hABCDE};
    vec[2] = '{1'b1, 4'b1001, 8'h15, 20'h12345, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 20'h0};
    vec[3] = '{1'b0, 4'b1111, 8'h15, 20'h12345, 1'b0, 1'b0, 4'b1001, 4'b1101, 4'b0100, 0, 20'h12345};
    vec[4] = '{1'b0, 4'b0011, 8'h15, 20'h12345, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 3, 20'h0};
    vec[5] = '{1'b0, 4'b1111, 8'h15, 20'hABCDF, 1'b0, 1'b0, 4'b0000, 4'b1101, 4'b0100, 2, 20'hABCDE};
    vec[6] = '{1'b1, 4'b0010, 8'h16, 20'h00777, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 0, 20'h0};
    vec[7] = '{1'b0, 4'b1111, 8'h16, 20'h00777, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1, 20'h00777};
    vec[8] = '{1'b1, 4'b0010, 8'h16, 20'h00777, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 20'h0};
    vec[9] = '{1'b0, 4'b0010, 8'h16, 20'h00777, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1, 20'h00777};

    idle();
    repeat (3) @(negedge clk);
    chk("reset busy", 256'(bus.flush_busy_o), 256'(1));
    chk("reset done", 256'(bus.flush_done_o), 256'(0));
    chk("reset ready", 256'(bus.tag_ready_o), 256'(0));
    chk("reset tag rsp flags", 256'({bus.tag_rsp_valid_o, bus.tag_rsp_valid_bits_o,
                                     bus.tag_rsp_dirty_o, bus.tag_rsp_hit_o}), 256'(0));
    chk("reset tag rsp tag", 256'(bus.tag_rsp_tag_o), 256'(0));
    chk("reset data rsp valid", 256'(bus.data_rsp_valid_o), 256'(0));
    chk("reset data rdata", 256'(bus.data_rdata_o), 256'(0));
    rst = 1'b0;
    wait_sweep("init", 256);

    // Every set reads back clean after the initial sweep.
    bad = 0;
    for (int s = 0; s < SET_NUM; s++) begin
      tag_op(1'b0, 4'b1111, 8'(s), 20'h0, 1'b0, 1'b0);
      @(negedge clk);
      if (bus.tag_rsp_valid_o !== 1'b1 || bus.tag_rsp_valid_bits_o !== 4'b0 ||
          bus.tag_rsp_dirty_o !== 4'b0 || bus.tag_rsp_hit_o !== 4'b0) bad++;
    end
    idle();
    chk("post-init sets not clean", 256'(bad), 256'(0));

    // Vector table, applied back to back.
    for (int i = 0; i < 10; i++) begin
      tag_op(vec[i].we, vec[i].en, vec[i].idx, vec[i].tag, vec[i].v, vec[i].d);
      @(negedge clk);
      if (vec[i].we) begin
        chk($sformatf("vec%0d write no rsp", i), 256'(bus.tag_rsp_valid_o), 256'(0));
      end else begin
        chk($sformatf("vec%0d rsp valid", i), 256'(bus.tag_rsp_valid_o), 256'(1));
        chk($sformatf("vec%0d hit", i), 256'(bus.tag_rsp_hit_o), 256'(vec[i].e_hit));
        chk($sformatf("vec%0d valid", i), 256'(bus.tag_rsp_valid_bits_o), 256'(vec[i].e_vld));
        chk($sformatf("vec%0d dirty", i), 256'(bus.tag_rsp_dirty_o), 256'(vec[i].e_dty));
        chk($sformatf("vec%0d tag way%0d", i, vec[i].tw),
            256'(bus.tag_rsp_tag_o[vec[i].tw]), 256'(vec[i].e_tag));
      end
    end
    idle();
    @(negedge clk);
    chk("idle rsp valid", 256'(bus.tag_rsp_valid_o), 256'(0));
    chk("idle flags", 256'({bus.tag_rsp_valid_bits_o, bus.tag_rsp_dirty_o, bus.tag_rsp_hit_o}), 256'(0));
    chk("idle tag hold", 256'(bus.tag_rsp_tag_o[1]), 256'(20'h00777));

    // Flush collides with a tag write: flush wins, write dropped.
    bus.flush_req_i = 1'b1;
    tag_op(1'b1, 4'b0100, 8'h15, 20'h55555, 1'b1, 1'b1);
    #1;
    chk("flush blocks ready", 256'(bus.tag_ready_o), 256'(0));
    @(negedge clk);
    idle();
    chk("flush started", 256'(bus.flush_busy_o), 256'(1));
    for (int i = 0; i < 50; i++) begin
      if (i == 10) tag_op(1'b0, 4'b1111, 8'h15, 20'hABCDE, 1'b0, 1'b0);
      @(negedge clk);
      if (i == 10) begin
        idle();
        chk("read during sweep ignored", 256'(bus.tag_rsp_valid_o), 256'(0));
      end
    end
    bus.flush_req_i = 1'b1;   // ignored mid-sweep
    @(negedge clk);
    bus.flush_req_i = 1'b0;
    wait_sweep("flush", 205);
    tag_op(1'b0, 4'b1111, 8'h15, 20'hABCDE, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    chk("flushed valid", 256'(bus.tag_rsp_valid_bits_o), 256'(0));
    chk("flushed dirty", 256'(bus.tag_rsp_dirty_o), 256'(0));
    chk("flushed hit", 256'(bus.tag_rsp_hit_o), 256'(0));
    chk("flushed tag way2 kept", 256'(bus.tag_rsp_tag_o[2]), 256'(20'hABCDE));
    chk("flushed tag way0 kept", 256'(bus.tag_rsp_tag_o[0]), 256'(20'h12345));

    // Byte-strobe merge.
    data_op(1'b1, 4'b0010, 11'h0A3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    @(negedge clk);
    data_op(1'b1, 4'b0010, 11'h0A3, 64'h1122_3344_5566_7788, 8'h0F);
    @(negedge clk);
    data_op(1'b0, 4'b0010, 11'h0A3, 64'h0, 8'h00);
    @(negedge clk);
    idle();
    edat = '0;
    edat[1] = 64'hFFFF_FFFF_5566_7788;
    chk("strobe rsp valid", 256'(bus.data_rsp_valid_o), 256'(1));
    chk("strobe merge", 256'(bus.data_rdata_o), 256'(edat));
    @(negedge clk);
    chk("data idle rsp", 256'(bus.data_rsp_valid_o), 256'(0));

    // Randomized tag traffic on sets 0x20..0x27.
    pool[0] = 20'h0; pool[1] = 20'h11111; pool[2] = 20'hFFFFF; pool[3] = 20'h5A5A5;
    for (int s = 0; s < 8; s++) begin
      tag_op(1'b1, 4'b1111, 8'(8'h20 + s), 20'h0, 1'b0, 1'b0);
      for (int w = 0; w < 4; w++) begin mt[w][s] = 20'h0; mv[w][s] = 0; md[w][s] = 0; end
      @(negedge clk);
    end
    idle();
    for (int k = 0; k < 300; k++) begin
      logic        we, v, d;
      logic [3:0]  en;
      logic [19:0] tg;
      int          s;
      we = 1'($urandom); en = 4'($urandom); s = $urandom_range(0, 7);
      tg = pool[$urandom_range(0, 3)]; v = 1'($urandom); d = 1'($urandom);
      tag_op(we, en, 8'(8'h20 + s), tg, v, d);
      @(negedge clk);
      idle();
      if (we) begin
        for (int w = 0; w < 4; w++)
          if (en[w]) begin mt[w][s] = tg; mv[w][s] = v; md[w][s] = d; end
      end else begin
        for (int w = 0; w < 4; w++) begin
          etag[w] = en[w] ? mt[w][s] : 20'h0;
          ev[w]   = en[w] && mv[w][s];
          ed[w]   = en[w] && md[w][s];
          eh[w]   = en[w] && mv[w][s] && (mt[w][s] == tg);
        end
        chk($sformatf("rnd%0d hit", k), 256'(bus.tag_rsp_hit_o), 256'(eh));
        chk($sformatf("rnd%0d state", k),
            256'({bus.tag_rsp_valid_o, bus.tag_rsp_valid_bits_o, bus.tag_rsp_dirty_o, bus.tag_rsp_tag_o}),
            256'({1'b1, ev, ed, etag}));
      end
    end

    // Randomized data traffic on lines 0x100..0x10F.
    for (int i = 0; i < 16; i++) begin
      logic [63:0] wd;
      wd = {$urandom, $urandom};
      data_op(1'b1, 4'b1111, 11'(11'h100 + i), wd, 8'hFF);
      for (int w = 0; w < 4; w++) mdat[w][i] = wd;
      @(negedge clk);
    end
    idle();
    for (int k = 0; k < 300; k++) begin
      logic        we;
      logic [3:0]  en;
      logic [7:0]  strb;
      logic [63:0] wd;
      int          i;
      we = 1'($urandom); en = 4'($urandom); strb = 8'($urandom);
      wd = {$urandom, $urandom}; i = $urandom_range(0, 15);
      data_op(we, en, 11'(11'h100 + i), wd, strb);
      @(negedge clk);
      idle();
      if (we) begin
        for (int w = 0; w < 4; w++)
          if (en[w])
            for (int b = 0; b < 8; b++)
              if (strb[b]) mdat[w][i][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        for (int w = 0; w < 4; w++) edat[w] = en[w] ? mdat[w][i] : 64'h0;
        chk($sformatf("drnd%0d valid", k), 256'(bus.data_rsp_valid_o), 256'(1));
        chk($sformatf("drnd%0d rdata", k), 256'(bus.data_rdata_o), 256'(edat));
      end
    end

    // Reset in the middle of a sweep, with a data response in flight.
    bus.flush_req_i = 1'b1;
    @(negedge clk);
    bus.flush_req_i = 1'b0;
    repeat (100) @(negedge clk);
    data_op(1'b0, 4'b1111, 11'h100, 64'h0, 8'h00);
    @(posedge clk);
    #1;
    idle();
    chk("pending data rsp", 256'(bus.data_rsp_valid_o), 256'(1));
    rst = 1'b1;
    #1;
    chk("mid reset drops rsp", 256'(bus.data_rsp_valid_o), 256'(0));
    chk("mid reset busy", 256'(bus.flush_busy_o), 256'(1));
    chk("mid reset ready", 256'(bus.tag_ready_o), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("restart", 256);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sy_l2_cache_array.md
Name: sy_L2_cache_array

Overview:
- Parametrised tag/state/data storage for the L2 cache, successor to the fixed-geometry L2 tag/data memory.
- Way count, set count, tag width and beats per line are configurable. Data writes take byte strobes. Tag reads return a registered per-way hit vector.
- Valid/dirty clearing uses a sequential sweep engine, one set per cycle. It replaces a single-cycle flush over all sets, which does not scale.
- Sits between the L2 controller pipeline and the SRAM wrappers.

Parameters:
WAY_NUM, 4, number of ways (1..8)
SET_NUM, 256, sets per way (power of two, >=2)
TAG_WTH, 20, stored tag bits
DATA_WTH, 64, data beat width in bits (multiple of 8)
BEAT_NUM, 8, data beats per cache line (power of two)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
flush_req_i  in  1  pulse: clear all valid and dirty bits
flush_busy_o  out  1  sweep in progress (init or flush)
flush_done_o  out  1  one-cycle pulse at sweep completion
tag_req_i  in  1  tag request valid
tag_ready_o  out  1  tag request accepted when req&ready
tag_we_i  in  1  1=write, 0=read
tag_way_en_i  in  WAY_NUM  way select (write: ways written; read: ways read)
tag_idx_i  in  log2(SET_NUM)  set index
tag_i  in  TAG_WTH  write tag / compare tag
tag_valid_i  in  1  valid bit to write
tag_dirty_i  in  1  dirty bit to write
tag_rsp_valid_o  out  1  read response valid
tag_rsp_tag_o  out  WAY_NUM*TAG_WTH  per-way stored tag
tag_rsp_valid_bits_o  out  WAY_NUM  per-way valid
tag_rsp_dirty_o  out  WAY_NUM  per-way dirty
tag_rsp_hit_o  out  WAY_NUM  per-way valid&&tag match
data_req_i  in  1  data request valid
data_we_i  in  1  1=write
data_way_en_i  in  WAY_NUM  way select
data_idx_i  in  log2(SET_NUM*BEAT_NUM)  {set,beat}
data_wdata_i  in  DATA_WTH  write data
data_wstrb_i  in  DATA_WTH/8  byte enables
data_rsp_valid_o  out  1  read data valid
data_rdata_o  out  WAY_NUM*DATA_WTH  per-way read data

Behaviour:
- Reset values:
  - flush_busy_o=1, flush_done_o=0, tag_ready_o=0.
  - All rsp valid outputs 0; hit/valid/dirty outputs 0; tag and data outputs 0.
- Sweep FSM states: IDLE, SWEEP, DONE.
  - Leaving reset, the FSM enters SWEEP with counter=0.
  - SWEEP: each cycle clears the valid and dirty bits of set counter in all ways; counter increments.
  - At counter==SET_NUM-1 the FSM clears that set and moves to DONE.
  - DONE: flush_done_o=1 for exactly one cycle, then IDLE.
  - Total sweep: SET_NUM cycles busy plus one DONE cycle.
- IDLE + flush_req_i: enter SWEEP at counter=0 next cycle. flush_req_i is ignored while SWEEP or DONE.
- Tag contents are untouched by the sweep; only valid and dirty are cleared.
- tag_ready_o = (state==IDLE) && !flush_req_i. A flush request in the same cycle as a tag request wins, and the tag request is not accepted.
- Tag read, 1-cycle latency:
  - Accepted read in cycle N gives tag_rsp_valid_o=1 in cycle N+1.
  - tag/valid/dirty are from the set indexed in N.
  - hit[w] = way_en[w] && valid[w] && tag[w]==tag_i registered in N.
  - Non-enabled ways return valid=0, dirty=0, hit=0, tag=0.
  - Cycles without an accepted read: rsp_valid=0, valid/dirty/hit=0, tag holds its last value.
- Tag write: accepted write in cycle N updates the enabled ways at the end of N. No response.
- Read-after-write to the same set: a read accepted in N+1 sees the write from N.
- Multiple write ways enabled: all enabled ways receive identical tag/valid/dirty.
- Data path:
  - Always ready; independent of the sweep.
  - Read latency 1: data_rsp_valid_o=1 in N+1. Enabled ways return RAM data; non-enabled ways return 0.
  - Write: only bytes with wstrb=1 are modified.
  - Data RAM is not reset; contents are undefined until written.
- Reset asserted mid-sweep or mid-request: sweep restarts from set 0 and any pending response is dropped.

Optional Feature:
SY_L2_ARRAY_PARITY_EN
- Defined:
  - Each tag entry stores an even-parity bit over {tag,valid,dirty}, written on tag write and set to 0 on sweep clear.
  - Adds output tag_parity_err_o (WAY_NUM), asserted alongside tag_rsp_valid_o for enabled ways whose recomputed parity mismatches.
  - hit is forced 0 for any way with a parity error.
- Undefined: no parity storage, no tag_parity_err_o port.

Test Plan:
- Reset release, SET_NUM=256 -> flush_busy_o=1 for 256 cycles, flush_done_o pulses in cycle 257, tag_ready_o=1 in cycle 258. Every set then reads valid=0, dirty=0.
- Write way2 set 0x15: tag=0xABCDE, valid=1, dirty=1. Then read set 0x15, all ways enabled, tag_i=0xABCDE -> next cycle hit=4'b0100, dirty=4'b0100, tag[2]=0xABCDE.
- Back-to-back write then read to the same set in consecutive cycles -> read returns the new tag; a mismatched compare tag gives hit=0.
- Data write idx 0x0A3, way1, wdata=0x1122334455667788, wstrb=0x0F over a prior value of all-ones -> readback 0xFFFFFFFF55667788.
- flush_req_i and tag_req_i in the same IDLE cycle -> tag request not accepted. After done, the previously written line reads valid=0, dirty=0 with the tag preserved.
- Reset asserted at sweep count 100 -> after release, the sweep restarts at 0 and runs the full 256 cycles.
